// File: rtl/mem_image_loader_pkg.sv
// rtl/mem_image_loader_pkg.sv - shared state encoding and frame constants for the image loader
package mem_image_loader_pkg;

    typedef enum logic [1:0] {
        ST_CNT_HI = 2'd0,
        ST_CNT_LO = 2'd1,
        ST_DATA   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/mem_image_loader_packer.sv
// rtl/mem_image_loader_packer.sv - assembles four bytes, MSB first, into a 32-bit word
module byte_word_packer
    import mem_image_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (valid_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            idx_q   <= idx_q + 2'd1;
        end
    end

    // The 4th byte is presented combinationally so the word is complete in its accept cycle.
    assign word_o      = {shift_q, byte_i};
    assign word_done_o = valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/mem_image_loader.sv
// rtl/mem_image_loader.sv - streams a counted byte image into the memory write port, then releases the CPU
module mem_image_loader
    import mem_image_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       widx_q, widx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;

    logic              accept;
    logic [31:0]       word;
    logic              word_done;

    assign in_ready = (state_q != ST_DONE);
    assign accept   = in_valid && in_ready;

    byte_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (state_q != ST_DATA),
        .byte_i      (in_data),
        .valid_i     (accept && (state_q == ST_DATA)),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        err_d   = err_q;
        unique case (state_q)
            ST_CNT_HI: begin
                if (accept) begin
                    n_d     = {in_data, 8'h00};
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    n_d     = {n_q[15:8], in_data};
                    widx_d  = '0;
                    state_d = ({n_q[15:8], in_data} == 16'd0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    // Words past the end of memory are consumed but dropped.
                    if ({1'b0, widx_q} < DEPTH_L) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(32'(BASE_ADDR) + 32'(widx_q));
                        wdata_d = word;
                    end else begin
                        err_d = 1'b1;
                    end
                    widx_d = widx_q + 16'd1;
                    if (widx_q + 16'd1 == n_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                hold_d  = 1'b0;
                state_d = ST_CNT_HI;
            end
            default: state_d = ST_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CNT_HI;
            n_q     <= '0;
            widx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign load_err  = err_q;
    assign load_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_image_loader.sv
// tb/tb_mem_image_loader.sv - scoreboard bench for mem_image_loader across default, small-depth and wrapping configurations
module tb_mem_image_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;

    logic [2:0]  rdy_v, we_v, done_v, hold_v, err_v;
    logic [9:0]  addr_v  [3];
    logic [31:0] wdata_v [3];

    always #5 clk = ~clk;

    mem_image_loader #(.ADDR_W(10), .DEPTH(1024), .BASE_ADDR(0)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_v[0]),
        .mem_we(we_v[0]), .mem_addr(addr_v[0]), .mem_wdata(wdata_v[0]),
        .cpu_hold(hold_v[0]), .load_done(done_v[0]), .load_err(err_v[0])
    );

    mem_image_loader #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(0)) u_dut_small (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_v[1]),
        .mem_we(we_v[1]), .mem_addr(addr_v[1]), .mem_wdata(wdata_v[1]),
        .cpu_hold(hold_v[1]), .load_done(done_v[1]), .load_err(err_v[1])
    );

    mem_image_loader #(.ADDR_W(10), .DEPTH(1024), .BASE_ADDR(1022)) u_dut_wrap (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_v[2]),
        .mem_we(we_v[2]), .mem_addr(addr_v[2]), .mem_wdata(wdata_v[2]),
        .cpu_hold(hold_v[2]), .load_done(done_v[2]), .load_err(err_v[2])
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          done_q[$];
    logic [31:0] img[$];

    int   checks   = 0;
    int   failures = 0;
    int   sel      = 0;
    int   ncyc     = 0;
    int   hi_due   = -1;
    logic prev_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   d;
        ncyc++;
        if (!reset) begin
            if (we_v[sel]) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_we", 64'(we_v[sel]), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("we_addr", 64'(addr_v[sel]), 64'(e.addr));
                    check_eq("we_data", 64'(wdata_v[sel]), 64'(e.data));
                    check_eq("we_cycle", 64'(ncyc), 64'(e.due));
                end
            end
            if (done_v[sel]) begin
                if (done_q.size() == 0) begin
                    check_eq("unexpected_done", 64'(done_v[sel]), 64'd0);
                end else begin
                    d = done_q.pop_front();
                    check_eq("done_cycle", 64'(ncyc), 64'(d));
                end
                check_eq("hold_at_done", 64'(hold_v[sel]), 64'd1);
                check_eq("ready_at_done", 64'(rdy_v[sel]), 64'd0);
            end
            if (prev_done) begin
                check_eq("hold_after_done", 64'(hold_v[sel]), 64'd0);
                check_eq("done_one_cycle", 64'(done_v[sel]), 64'd0);
            end
            if (ncyc == hi_due) begin
                check_eq("hold_after_cnt_hi", 64'(hold_v[sel]), 64'd1);
                check_eq("err_clear_on_cnt_hi", 64'(err_v[sel]), 64'd0);
            end
            prev_done = done_v[sel];
        end
    end

    // All driver activity happens 1 time unit after a clock edge.
    task automatic send_byte(input logic [7:0] b, output int fc);
        int guard;
        guard    = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk); #1;
        while (!rdy_v[0] && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!rdy_v[0]) check_eq("ready_timeout", 64'(rdy_v[0]), 64'd1);
        fc = ncyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int n, input int base, input int depth, input int gapmode);
        logic [15:0] nn;
        logic [31:0] wd;
        int          fc;
        nn = 16'(n);
        send_byte(nn[15:8], fc);
        hi_due = fc + 1;
        if (gapmode != 0) idle(1);
        send_byte(nn[7:0], fc);
        if (gapmode != 0) idle(1);
        if (n == 0) done_q.push_back(fc + 1);
        for (int w = 0; w < n; w++) begin
            wd = img[w];
            for (int k = 0; k < 4; k++) begin
                send_byte(wd[31-8*k -: 8], fc);
                if (k == 3) begin
                    if (w < depth) exp_q.push_back('{addr: 10'(base + w), data: wd, due: fc + 1});
                    if (w == n - 1) done_q.push_back(fc + 1);
                end
                if (gapmode != 0) idle(1);
                if (gapmode != 0 && w == 0 && k == 1) idle(5);
            end
        end
        idle(4);
        check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check_eq("done_q_drained", 64'(done_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_we", 64'(we_v[i]), 64'd0);
            check_eq("rst_addr", 64'(addr_v[i]), 64'd0);
            check_eq("rst_wdata", 64'(wdata_v[i]), 64'd0);
            check_eq("rst_done", 64'(done_v[i]), 64'd0);
            check_eq("rst_err", 64'(err_v[i]), 64'd0);
            check_eq("rst_hold", 64'(hold_v[i]), 64'd1);
            check_eq("rst_ready", 64'(rdy_v[i]), 64'd1);
        end
        reset  = 1'b0;
        hi_due = -1;
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();

        // Back-to-back two-word frame.
        sel = 0;
        img.delete();
        img.push_back(32'h20020005);
        img.push_back(32'h0000000C);
        send_frame(2, 0, 1024, 0);

        // Same frame with alternating valid and a mid-word stall.
        send_frame(2, 0, 1024, 1);

        // Empty image.
        send_frame(0, 0, 1024, 0);

        // Overflow on a 4-word memory.
        sel = 1;
        img.delete();
        for (int i = 1; i <= 5; i++) img.push_back(32'(i));
        send_frame(5, 0, 4, 0);
        idle(3);
        check_eq("err_sticky", 64'(err_v[1]), 64'd1);
        send_frame(0, 0, 4, 0);

        // Reset mid-word, then a fresh one-word frame.
        sel = 0;
        send_byte(8'h00, fc);
        send_byte(8'h03, fc);
        send_byte(8'h11, fc);
        send_byte(8'h22, fc);
        do_reset();
        img.delete();
        img.push_back(32'hDEADBEEF);
        send_frame(1, 0, 1024, 0);

        // Address wrap from base 1022.
        sel = 2;
        img.delete();
        img.push_back(32'hA5A5_0001);
        img.push_back(32'h5A5A_0002);
        img.push_back(32'hC3C3_0003);
        send_frame(3, 1022, 1024, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_image_loader.md
Name: mem_image_loader

Overview:
- Streaming writer that fills the CPU's unified instruction/data memory from a byte stream, then releases the CPU from hold.
- Replaces the simulation-only $readmemh load with a synthesizable path: host/UART side → loader → memory write port.
- Sits beside the memory; `cpu_hold` gates the CPU PC/regfile writes until the image is resident.

Parameters:
- ADDR_W, 10, word-address width of the memory write port.
- DEPTH, 1024, number of 32-bit words in memory; must be ≤ 2^ADDR_W.
- BASE_ADDR, 0, word address where word 0 of the image is written.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte this cycle; a byte transfers when in_valid & in_ready.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  high = CPU held (no fetch/commit).
- load_done  out  1  one-cycle pulse when the image is complete.
- load_err  out  1  sticky: image word count exceeded DEPTH.

Behaviour:
- Frame format: 2-byte word count N (MSB first), then N×4 data bytes. Each word is assembled MSB first, matching hex-image text order.
- States:
  - CNT_HI: accept byte → N[15:8]; go to CNT_LO. Set cpu_hold=1.
  - CNT_LO: accept byte → N[7:0]. If N==0 go to DONE, else go to DATA with word index=0 and byte index=0.
  - DATA: accept bytes into a shift register. On the 4th byte, register the write and increment the word index. After the Nth word go to DONE.
  - DONE: in_ready=0; load_done=1 for exactly one cycle; cpu_hold=0 from the next cycle; return to CNT_HI.
- in_ready=1 in CNT_HI, CNT_LO and DATA; 0 in DONE. The loader never stalls mid-word; the source may insert idle cycles (in_valid=0) anywhere, and byte index/state hold unchanged during them.
- Write latency: mem_we/mem_addr/mem_wdata are registered and asserted in the cycle after the 4th byte of a word is accepted. mem_addr = BASE_ADDR + word index, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
- Overflow: for word index ≥ DEPTH, mem_we stays 0 (word dropped) and load_err is set. All bytes are still consumed and the frame completes normally, including the load_done pulse. load_err clears only on reset or on acceptance of the next frame's CNT_HI byte.
- cpu_hold behaviour:
  - 1 out of reset, so the CPU is held until the first image completes.
  - Goes to 1 again in the cycle after a new CNT_HI byte is accepted.
  - Goes to 0 the cycle after DONE.
- The final word's mem_we occurs in the same cycle as the DONE state, so load_done coincides with the last write. cpu_hold is therefore still 1 during that write.
- Reset (any cycle, including mid-word or mid-frame):
  - state=CNT_HI; N, word index, byte index and shift register cleared.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_err=0, cpu_hold=1, in_ready=1 on the first post-reset cycle.
  - The partial frame is abandoned; no write occurs for a partial word.
- Width rules: the word counter is 16 bits; the word-index vs DEPTH compare is done at 16 bits (no truncation).

Decomposition:
- Shared package/header holds the state encoding constants (ST_CNT_HI, ST_CNT_LO, ST_DATA, ST_DONE) and the frame header byte count (2).
- One natural sub-module: `byte_word_packer`. It holds the 4-byte shift register and 2-bit byte index, and outputs a word-complete flag. It is reusable for a future result-dump path.

Test Plan:
1. Reset, then stream 00 02 | 20 02 00 05 | 00 00 00 0C with no gaps → writes addr0=32'h20020005 and addr1=32'h0000000C, one cycle after each 4th byte. load_done pulses with the second write; cpu_hold falls the next cycle.
2. Same frame with in_valid toggled 1/0 every cycle and a 5-cycle gap mid-word → identical writes and data; no extra mem_we.
3. Frame 00 00 → no mem_we; load_done pulse 1 cycle after the 2nd byte; cpu_hold 1→0.
4. DEPTH=4, frame N=5 with words 1..5 → writes words 1–4 to addr0–3; word 5 is not written; load_err=1 stays set after done; the next frame's first byte clears it.
5. Reset asserted after 2 bytes of word 1 in a N=3 frame, then a fresh N=1 frame with DEADBEEF → only a write of 32'hDEADBEEF at addr0; all outputs at reset values during the reset cycle.
6. BASE_ADDR=1022, ADDR_W=10, N=3 → writes at addresses 1022, 1023, 0 (wrap).
